// File: rtl/bch_multilane_dec.sv
// Multi-lane BCH(26,16) decode stage (shortened BCH(31,21), t=2), with valid/bypass
// alignment, per-lane error flags and saturating link-health counters.
module bch_31_pipe #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] codeword,
    output logic [25:0] corrected_codeword_o,
    output logic        error_detected
);
    // g(x) = x^10 + x^9 + x^8 + x^6 + x^5 + x^3 + 1
    localparam logic [25:0] GEN = 26'h769;

    function automatic logic [9:0] rem(input logic [25:0] c);
        logic [25:0] r;
        r = c;
        for (int i = 25; i >= 10; i--)
            if (r[i]) r = r ^ (GEN << (i - 10));
        return r[9:0];
    endfunction

    logic [25:0] cw_q;
    logic [9:0]  syn_q;
    logic [25:0] fix;
    logic [26:0] sh [LAT-1];

    // Every weight-1 and weight-2 error has a unique syndrome (dmin = 5),
    // so a direct syndrome match locates up to two flipped bits.
    always_comb begin
        fix = '0;
        for (int i = 0; i < 26; i++) begin
            if (syn_q == rem(26'd1 << i)) fix[i] = 1'b1;
            for (int j = i + 1; j < 26; j++) begin
                if (syn_q == (rem(26'd1 << i) ^ rem(26'd1 << j))) begin
                    fix[i] = 1'b1;
                    fix[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_q  <= '0;
            syn_q <= '0;
            for (int k = 0; k < LAT - 1; k++) sh[k] <= '0;
        end else begin
            cw_q  <= codeword;
            syn_q <= rem(codeword);
            sh[0] <= {|syn_q, cw_q ^ fix};
            for (int k = 1; k < LAT - 1; k++) sh[k] <= sh[k-1];
        end
    end

    assign corrected_codeword_o = sh[LAT-2][25:0];
    assign error_detected       = sh[LAT-2][26];
endmodule

module bch_multilane_dec #(
    parameter int NUM_LANES = 2,
    parameter int DEC_LAT   = 2,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [NUM_LANES*26-1:0]   data_in,
    input  logic                      ecc_en,
    input  logic                      cnt_clr,
    output logic                      out_valid,
    output logic [NUM_LANES*16-1:0]   word_out,
    output logic [NUM_LANES-1:0]      lane_err,
    output logic                      error_detected,
    output logic [CNT_W-1:0]          word_cnt,
    output logic [CNT_W-1:0]          err_word_cnt,
    output logic                      err_sticky,
    output logic                      cnt_sat
);
    localparam int DW = NUM_LANES * 16;

    logic [NUM_LANES*16-1:0] corr_data;
    logic [NUM_LANES*10-1:0] unused_parity;
    logic [NUM_LANES-1:0]    dec_err;
    logic [DW-1:0]           raw_in;
    logic [DW-1:0]           raw_sh [DEC_LAT];
    logic [DEC_LAT-1:0]      v_sh;
    logic [DEC_LAT-1:0]      e_sh;
    logic                    v_al;
    logic                    e_al;
    logic [DW-1:0]           word_n;
    logic [NUM_LANES-1:0]    lane_err_n;
    logic                    err_n;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        bch_31_pipe #(.LAT(DEC_LAT)) u_dec (
            .clk                  (clk),
            .rst                  (rst),
            .codeword             (data_in[26*k +: 26]),
            .corrected_codeword_o ({corr_data[16*k +: 16], unused_parity[10*k +: 10]}),
            .error_detected       (dec_err[k])
        );
        assign raw_in[16*k +: 16] = data_in[26*k+10 +: 16];
        assign word_n[16*k +: 16] = e_al ? corr_data[16*k +: 16] : raw_sh[DEC_LAT-1][16*k +: 16];
    end

    assign v_al       = v_sh[DEC_LAT-1];
    assign e_al       = e_sh[DEC_LAT-1];
    assign lane_err_n = e_al ? dec_err : '0;
    assign err_n      = v_al & (|lane_err_n);

    // Qualifiers and raw data follow the decoder pipeline so bypass has equal latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_sh <= '0;
            e_sh <= '0;
            for (int k = 0; k < DEC_LAT; k++) raw_sh[k] <= '0;
        end else begin
            v_sh[0]   <= in_valid;
            e_sh[0]   <= ecc_en;
            raw_sh[0] <= raw_in;
            for (int k = 1; k < DEC_LAT; k++) begin
                v_sh[k]   <= v_sh[k-1];
                e_sh[k]   <= e_sh[k-1];
                raw_sh[k] <= raw_sh[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            word_out       <= '0;
            lane_err       <= '0;
            error_detected <= 1'b0;
            word_cnt       <= '0;
            err_word_cnt   <= '0;
            err_sticky     <= 1'b0;
            cnt_sat        <= 1'b0;
        end else begin
            out_valid      <= v_al;
            error_detected <= err_n;
            if (v_al) begin
                word_out <= word_n;
                lane_err <= lane_err_n;
            end
            // A clear on the same edge drops the word's contribution entirely.
            if (cnt_clr) begin
                word_cnt     <= '0;
                err_word_cnt <= '0;
                err_sticky   <= 1'b0;
                cnt_sat      <= 1'b0;
            end else begin
                if (v_al && (word_cnt != '1))     word_cnt     <= word_cnt + 1'b1;
                if (err_n && (err_word_cnt != '1)) err_word_cnt <= err_word_cnt + 1'b1;
                if (err_n) err_sticky <= 1'b1;
                cnt_sat <= (&word_cnt) | (&err_word_cnt);
            end
        end
    end
endmodule

// File: tb/tb_bch_multilane_dec.sv
// Testbench for bch_multilane_dec: directed and random words checked against an
// error-count based reference model with a fixed-latency scoreboard.
module tb_bch_multilane_dec;
    localparam int NL  = 2;
    localparam int LAT = 3;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, in_valid, ecc_en, cnt_clr;
    logic [NL*26-1:0] data_in;
    logic out_valid, error_detected, err_sticky, cnt_sat;
    logic [NL*16-1:0] word_out;
    logic [NL-1:0] lane_err;
    logic [CW-1:0] word_cnt, err_word_cnt;

    always #5 clk = ~clk;

    bch_multilane_dec #(.NUM_LANES(NL), .DEC_LAT(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .ecc_en(ecc_en),
        .cnt_clr(cnt_clr), .out_valid(out_valid), .word_out(word_out), .lane_err(lane_err),
        .error_detected(error_detected), .word_cnt(word_cnt), .err_word_cnt(err_word_cnt),
        .err_sticky(err_sticky), .cnt_sat(cnt_sat)
    );

    typedef struct {
        bit          v;
        logic [31:0] word;
        logic [1:0]  lerr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_word;
    logic [1:0]  exp_lerr;
    logic [31:0] m_word;
    logic [1:0]  m_lerr;
    bit m_valid, m_err, m_sticky, m_sat;
    int m_wc, m_ec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] encode(input logic [15:0] d);
        logic [25:0] r;
        r = {d, 10'd0};
        for (int i = 25; i >= 10; i--)
            if (r[i]) r = r ^ (26'h769 << (i - 10));
        return {d, r[9:0]};
    endfunction

    // Build one lane: nerr bit flips (pos >= 0 forces the first flip position).
    task automatic lane(input int k, input logic [15:0] d, input int nerr, input int pos);
        logic [25:0] cw;
        int p0, p1;
        cw = encode(d);
        p0 = (pos >= 0) ? pos : int'($urandom_range(0, 25));
        p1 = (p0 + 1 + int'($urandom_range(0, 24))) % 26;
        if (nerr >= 1) cw[p0] = ~cw[p0];
        if (nerr >= 2) cw[p1] = ~cw[p1];
        data_in[26*k +: 26] = cw;
        exp_word[16*k +: 16] = ecc_en ? d : cw[25:10];
        exp_lerr[k] = ecc_en && (nerr > 0);
    endtask

    task automatic word(input bit v, input bit e, input logic [15:0] d0, input logic [15:0] d1,
                        input int n0, input int n1, input int pos1);
        in_valid = v;
        ecc_en = e;
        lane(0, d0, n0, -1);
        lane(1, d1, n1, pos1);
    endtask

    task automatic idle();
        word(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
    endtask

    task automatic tick(input bit c, input bit r);
        exp_t e;
        bit werr;
        cnt_clr = c;
        rst = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_valid = 0; m_err = 0; m_word = '0; m_lerr = '0;
            m_wc = 0; m_ec = 0; m_sticky = 0; m_sat = 0;
        end else begin
            e.v = in_valid; e.word = exp_word; e.lerr = exp_lerr;
            q.push_back(e);
            if (q.size() == LAT) e = q.pop_front();
            else e.v = 0;
            werr = e.v && (|e.lerr);
            m_valid = e.v;
            m_err = werr;
            if (e.v) begin m_word = e.word; m_lerr = e.lerr; end
            if (c) begin
                m_wc = 0; m_ec = 0; m_sticky = 0; m_sat = 0;
            end else begin
                m_sat = (m_wc == CMAX) || (m_ec == CMAX);
                if (e.v && m_wc < CMAX) m_wc++;
                if (werr && m_ec < CMAX) m_ec++;
                if (werr) m_sticky = 1;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("word_out", 64'(word_out), 64'(m_word));
        chk("lane_err", 64'(lane_err), 64'(m_lerr));
        chk("error_detected", 64'(error_detected), 64'(m_err));
        chk("word_cnt", 64'(word_cnt), 64'(m_wc));
        chk("err_word_cnt", 64'(err_word_cnt), 64'(m_ec));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("cnt_sat", 64'(cnt_sat), 64'(m_sat));
    endtask

    initial begin
        in_valid = 0; ecc_en = 1; cnt_clr = 0; rst = 1; data_in = '0;
        exp_word = '0; exp_lerr = '0;
        idle(); tick(0, 1);
        idle(); tick(0, 1);
        chk("reset_word", 64'(word_out), 64'h0);

        // Four clean back-to-back words.
        for (int i = 0; i < 4; i++) begin
            word(1, 1, 16'h1234, 16'hABCD, 0, 0, -1);
            tick(0, 0);
        end
        for (int i = 0; i < 3; i++) begin idle(); tick(0, 0); end
        chk("clean_word", 64'(word_out), 64'hABCD_1234);
        chk("clean_cnt", 64'(word_cnt), 64'd4);

        // Single error on lane1 codeword bit 17 (data bit 7), corrected.
        word(1, 1, 16'h1234, 16'hABCD, 0, 1, 17);
        tick(0, 0);
        idle(); tick(0, 0);
        idle(); tick(0, 0);
        chk("corr_word", 64'(word_out), 64'hABCD_1234);
        chk("corr_lane_err", 64'(lane_err), 64'b10);
        chk("corr_err_cnt", 64'(err_word_cnt), 64'd1);

        // Same error in bypass.
        word(1, 0, 16'h1234, 16'hABCD, 0, 1, 17);
        tick(0, 0);
        idle(); tick(0, 0);
        idle(); tick(0, 0);
        chk("byp_word", 64'(word_out), 64'hAB4D_1234);
        chk("byp_err_cnt", 64'(err_word_cnt), 64'd1);

        // ecc_en alternating per word, each with errors.
        for (int i = 0; i < 6; i++) begin
            word(1, 1'(i % 2 == 0), 16'($urandom), 16'($urandom), 1, 2, -1);
            tick(0, 0);
        end
        // Gapped input 1,0,1.
        word(1, 1, 16'h5A5A, 16'hC3C3, 0, 0, -1); tick(0, 0);
        idle(); tick(0, 0);
        word(1, 1, 16'h0F0F, 16'hF0F0, 0, 0, -1); tick(0, 0);
        for (int i = 0; i < 4; i++) begin idle(); tick(0, 0); end

        // Random mix of valid, mode, error count and occasional clear.
        for (int i = 0; i < 120; i++) begin
            word(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
            tick(1'($urandom_range(0, 15) == 0), 0);
        end

        // Saturation with 20 erroneous words.
        idle(); tick(1, 0);
        for (int i = 0; i < 20; i++) begin
            word(1, 1, 16'($urandom), 16'($urandom), 1, 0, -1);
            tick(0, 0);
        end
        for (int i = 0; i < 4; i++) begin idle(); tick(0, 0); end
        chk("sat_wc", 64'(word_cnt), 64'(CMAX));
        chk("sat_ec", 64'(err_word_cnt), 64'(CMAX));
        chk("sat_flag", 64'(cnt_sat), 64'd1);

        // Clear coincident with an erroneous output word.
        word(1, 1, 16'h1111, 16'h2222, 2, 1, -1); tick(0, 0);
        idle(); tick(0, 0);
        idle(); tick(1, 0);
        chk("clr_sticky", 64'(err_sticky), 64'd0);
        chk("clr_wc", 64'(word_cnt), 64'd0);
        idle(); tick(0, 0);

        // Reset with two erroneous words in flight.
        word(1, 1, 16'h3333, 16'h4444, 1, 1, -1); tick(0, 0);
        word(1, 1, 16'h5555, 16'h6666, 0, 1, -1); tick(0, 0);
        idle(); tick(0, 1);
        idle(); tick(0, 0);
        word(1, 1, 16'h7777, 16'h8888, 0, 1, -1); tick(0, 0);
        idle(); tick(0, 0);
        idle(); tick(0, 0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_word", 64'(word_out), 64'h8888_7777);
        for (int i = 0; i < 3; i++) begin idle(); tick(0, 0); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bch_multilane_dec.md
Name: bch_multilane_dec

Overview:
- Streaming, N-lane BCH(26,16) decode stage built from NUM_LANES parallel bch_31_pipe instances.
- Each lane carries one 26-bit shortened codeword: 16 data bits and 10 parity bits.
- Adds input/output valid qualification, a per-lane error vector, and a per-word ECC bypass mode.
- Adds saturating word and error counters with synchronous clear, plus a sticky error flag, for link-health monitoring.

Parameters:
- NUM_LANES, 2, number of parallel codeword lanes (1..8).
- DEC_LAT, 2, latency in cycles of one bch_31_pipe instance, from codeword to corrected_codeword_o/error_detected.
- CNT_W, 16, width of the saturating counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  data_in holds a valid multi-lane word this cycle
- data_in  in  NUM_LANES*26  lane k at [26k+25:26k]; data [26k+25:26k+10], parity [26k+9:26k]
- ecc_en  in  1  1 = decode and correct, 0 = bypass; sampled with in_valid
- cnt_clr  in  1  synchronous clear of counters and sticky flag
- out_valid  out  1  word_out/lane_err valid this cycle
- word_out  out  NUM_LANES*16  lane k corrected data at [16k+15:16k]
- lane_err  out  NUM_LANES  per-lane error_detected, qualified
- error_detected  out  1  OR of lane_err, qualified by out_valid
- word_cnt  out  CNT_W  number of valid output words since clear
- err_word_cnt  out  CNT_W  number of valid output words with error_detected=1
- err_sticky  out  1  set on any error_detected, held until cnt_clr/rst
- cnt_sat  out  1  high while either counter is at all-ones

Behaviour:
- Reset:
  - rst is synchronous and also drives the rst input of every bch_31_pipe instance.
  - All of the following clear to 0: out_valid, word_out, lane_err, error_detected, word_cnt, err_word_cnt, err_sticky, cnt_sat, and every valid/ecc_en delay stage.
- Datapath:
  - Decoders run freely on data_in every cycle.
  - A DEC_LAT-deep shift register carries in_valid, ecc_en and the raw data bits of every lane, aligned with the decoder outputs.
- Output register:
  - One output register stage follows alignment, so total latency LAT = DEC_LAT+1 (default 3).
  - in_valid at cycle t produces out_valid at cycle t+LAT.
- Throughput:
  - One word per cycle, with no bubbles required.
  - Back-to-back in_valid yields back-to-back out_valid.
  - There is no backpressure.
- Word and flag update:
  - When the aligned valid is 1, word_out, lane_err and error_detected load.
  - Otherwise these outputs hold their last values, except error_detected, which is driven 0.
  - out_valid is 0 whenever the aligned valid is 0.
- ECC enabled: word_out lane k = corrected_codeword_o[25:10] of lane k; lane_err[k] = error_detected of lane k.
- Bypass (aligned ecc_en=0):
  - word_out lane k = raw delayed data bits [25:10] of lane k.
  - lane_err = 0 and error_detected = 0.
  - Latency is identical to the enabled case.
- ecc_en per word: may change every cycle; each word uses the ecc_en sampled with its own in_valid.
- Counters, updated on cycles where out_valid is being asserted:
  - word_cnt increments by 1.
  - err_word_cnt increments by 1 if the word's error_detected=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- cnt_sat: asserted the cycle after either counter reaches all-ones.
- cnt_clr:
  - Zeroes word_cnt, err_word_cnt, err_sticky and cnt_sat on the next edge.
  - Clear wins over a coincident increment or sticky set; that event is not counted.
  - Does not affect the datapath or words in flight.
- err_sticky: set on the edge where error_detected is registered as 1; cleared only by cnt_clr or rst.
- Reset mid-stream:
  - All in-flight words are discarded and no out_valid appears for them.
  - The first out_valid after reset release is LAT cycles after the first new in_valid.
- Reset during an error: the error does not set err_sticky and is not counted.

Test Plan:
- Reset, then 4 back-to-back clean codewords (lane0 data 16'h1234, lane1 data 16'hABCD, valid parity) -> out_valid high 4 cycles starting 3 cycles after first in_valid; word_out=32'hABCD_1234; error_detected=0; word_cnt=4; err_word_cnt=0.
- Flip bit 17 of lane1 codeword (data 16'hABCD) -> word_out=32'hABCD_1234; lane_err=2'b10; error_detected=1; err_word_cnt=1; err_sticky=1.
- Bypass:
  - Same single-bit error with ecc_en=0 -> word_out upper half = 16'hABCD^16'h0080 (uncorrected); lane_err=0; err_word_cnt unchanged.
  - ecc_en alternates 1/0 on consecutive words -> correct per-word mode.
- Gapped input (in_valid 1,0,1) -> out_valid 1,0,1 at t+3; word_out holds during gap; error_detected=0 in gap.
- CNT_W=4:
  - 20 erroneous words -> both counters stop at 15; cnt_sat=1.
  - cnt_clr coincident with an erroneous out_valid -> counters=0, err_sticky=0, that word not counted.
- rst asserted 1 cycle after 2 in-flight words -> neither appears on out_valid; all outputs 0; post-reset word emerges exactly LAT cycles after its in_valid.
